// File: rtl/display_pkg.sv
// Shared 640x480@60 timing constants and the bot display-state record for the
// display timing generator.
package display_pkg;

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned PIPE_DLY = 2;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic SYNC_POL      = 1'b0;
  localparam logic SYNC_INACTIVE = ~SYNC_POL;

  typedef struct packed {
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic [7:0] bot_info;
  } bot_state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Clk-rate shift register that lines video_on/syncs up with the renderer
// pipeline; DEPTH of zero is a plain wire.
module sync_delay_line #(
  parameter int unsigned      WIDTH     = 3,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, reset_n};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/display_timing_gen.sv
// VGA scan timing (pixel divider, h/v counters, delayed syncs) plus the bot-state
// shadow registers, which only change at the start of vertical blank.
module display_timing_gen #(
  parameter int unsigned CLK_DIV  = display_pkg::CLK_DIV,
  parameter int unsigned H_ACTIVE = display_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = display_pkg::H_FP,
  parameter int unsigned H_SYNC   = display_pkg::H_SYNC,
  parameter int unsigned H_BP     = display_pkg::H_BP,
  parameter int unsigned V_ACTIVE = display_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = display_pkg::V_FP,
  parameter int unsigned V_SYNC   = display_pkg::V_SYNC,
  parameter int unsigned V_BP     = display_pkg::V_BP,
  parameter logic        SYNC_POL = display_pkg::SYNC_POL,
  parameter int unsigned PIPE_DLY = display_pkg::PIPE_DLY
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic                           pix_tick,
  output logic [display_pkg::CNT_W-1:0]  pixel_column,
  output logic [display_pkg::CNT_W-1:0]  pixel_row,
  output logic                           video_on,
  output logic                           horiz_sync,
  output logic                           vert_sync,
  output logic                           frame_start,
  input  logic [7:0]                     LocX_in,
  input  logic [7:0]                     LocY_in,
  input  logic [7:0]                     BotInfo_in,
  input  logic                           upd_req,
  output logic                           upd_ack,
  output logic [7:0]                     LocX_reg,
  output logic [7:0]                     LocY_reg,
  output logic [7:0]                     BotInfo_reg
);

  localparam int unsigned CntW = display_pkg::CNT_W;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast     = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HActive     = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] HLast       = CntW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CntW-1:0] HsStart     = CntW'(H_ACTIVE + H_FP);
  localparam logic [CntW-1:0] HsEnd       = CntW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntW-1:0] VActive     = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] VActiveLast = CntW'(V_ACTIVE - 1);
  localparam logic [CntW-1:0] VLast       = CntW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CntW-1:0] VsStart     = CntW'(V_ACTIVE + V_FP);
  localparam logic [CntW-1:0] VsEnd       = CntW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic            SyncInactive = ~SYNC_POL;

  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] h_q, h_d, v_q, v_d;
  logic            frame_start_q, frame_start_d;

  display_pkg::bot_state_t bot_in, pend_q, pend_d, disp_q, disp_d;
  logic                    pend_valid_q, pend_valid_d;

  logic video_raw, hs_raw, vs_raw;

  // Scan counters
  assign pix_tick = (div_q == DivLast);

  always_comb begin
    div_d         = pix_tick ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      if (h_q == HLast) begin
        h_d           = '0;
        v_d           = (v_q == VLast) ? '0 : v_q + 1'b1;
        frame_start_d = (v_q == VActiveLast);
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_column = h_q;
  assign pixel_row    = v_q;
  assign frame_start  = frame_start_q;

  // Raw video/sync, delayed to match the renderer latency
  assign video_raw = (h_q < HActive) && (v_q < VActive);
  assign hs_raw    = ((h_q >= HsStart) && (h_q < HsEnd)) ? SYNC_POL : SyncInactive;
  assign vs_raw    = ((v_q >= VsStart) && (v_q < VsEnd)) ? SYNC_POL : SyncInactive;

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL ({1'b0, SyncInactive, SyncInactive})
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({video_raw, hs_raw, vs_raw}),
    .q       ({video_on, horiz_sync, vert_sync})
  );

  // Update handshake; a request landing on the commit cycle bypasses pending
  assign bot_in = {LocX_in, LocY_in, BotInfo_in};

  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    upd_ack      = 1'b0;
    if (upd_req) begin
      pend_d       = bot_in;
      pend_valid_d = 1'b1;
    end
    if (frame_start_q && (upd_req || pend_valid_q)) begin
      disp_d       = upd_req ? bot_in : pend_q;
      pend_valid_d = 1'b0;
      upd_ack      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
    end
  end

  assign LocX_reg    = disp_q.loc_x;
  assign LocY_reg    = disp_q.loc_y;
  assign BotInfo_reg = disp_q.bot_info;

endmodule
